// File: rtl/bcd_conv_sched.sv
// ============================================================================
// Module   : bcd_conv_sched
// Brief    : Round-robin shared binary-to-BCD converter (double-dabble, 1 bit/cycle)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_conv_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   i_req_valid,
  input  logic [8*NREQ-1:0] i_req_bin,
  output logic [NREQ-1:0]   o_req_ready,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [11:0]       o_out_bcd,
  output logic [IDW-1:0]    o_out_id,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [7:0]      r_sreg;
  logic [11:0]     r_acc;
  logic [11:0]     w_acc_shift;
  logic [2:0]      r_cnt;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  w_grant;
  logic            w_found;
  logic [7:0]      w_sel_bin;
  logic [11:0]     r_out_bcd;
  logic [IDW-1:0]  r_out_id;

  function automatic logic [3:0] f_corr(input logic [3:0] n);
    return (n > 4'd4) ? n + 4'd3 : n;
  endfunction

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int v_idx;
    v_idx   = 0;
    w_found = 1'b0;
    w_grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      v_idx = (int'(r_last) + k) % NREQ;
      if (!w_found && i_req_valid[v_idx]) begin
        w_found = 1'b1;
        w_grant = IDW'(v_idx);
      end
    end
  end

  assign w_sel_bin = i_req_bin[8*int'(w_grant) +: 8];

  // Hundreds digit never exceeds 2, so only its low 3 corrected bits survive the shift.
  assign w_acc_shift = {3'(f_corr(r_acc[11:8])), f_corr(r_acc[7:4]),
                        f_corr(r_acc[3:0]), r_sreg[7]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_SHIFT;
          o_req_ready = NREQ'(1) << w_grant;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 3'd7) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg    <= 8'h00;
      r_acc     <= 12'h000;
      r_cnt     <= 3'd0;
      r_last    <= IDW'(NREQ - 1);
      r_out_bcd <= 12'h000;
      r_out_id  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_sreg   <= w_sel_bin;
            r_acc    <= 12'h000;
            r_cnt    <= 3'd0;
            r_out_id <= w_grant;
            r_last   <= w_grant;
          end
        end
        S_SHIFT: begin
          r_acc  <= w_acc_shift;
          r_sreg <= {r_sreg[6:0], 1'b0};
          r_cnt  <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            r_out_bcd <= w_acc_shift;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_out_valid = (r_state == S_DONE);
  assign o_busy      = (r_state != S_IDLE);
  assign o_out_bcd   = r_out_bcd;
  assign o_out_id    = r_out_id;

endmodule

`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
// ============================================================================
// Module   : tb_bcd_conv_sched
// Brief    : Scoreboard bench for bcd_conv_sched with a round-robin reference model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_conv_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   i_req_valid = '0;
  logic [8*NREQ-1:0] i_req_bin = '0;
  logic [NREQ-1:0]   o_req_ready;
  logic              o_out_valid;
  logic              i_out_ready = 1'b1;
  logic [11:0]       o_out_bcd;
  logic [IDW-1:0]    o_out_id;
  logic              o_busy;

  always #5 clk = ~clk;

  bcd_conv_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_bin   (i_req_bin),
    .o_req_ready (o_req_ready),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_bcd   (o_out_bcd),
    .o_out_id    (o_out_id),
    .o_busy      (o_busy)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [11:0]    bcd;
  } exp_t;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   xfer_q[$];
  bit   model_idle = 1'b1;
  int   model_last = NREQ - 1;
  int   sidx = 0;
  int   acc_idx = 0;
  bit   prev_hold = 1'b0;
  logic [11:0]    held_bcd = '0;
  logic [IDW-1:0] held_id = '0;
  bit   rdy_rand = 1'b0;
  logic rdy_fix = 1'b1;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    i_out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  end

  // Monitor: samples just before each rising edge, predicts grants and pops results.
  always @(negedge clk) begin : obs
    bit              idle_now;
    bit              exp_valid;
    int              g;
    logic [NREQ-1:0] exp_rdy;
    exp_t            e;
    #4;
    if (!rst_n) begin
      sb.delete();
      model_idle = 1'b1;
      model_last = NREQ - 1;
      prev_hold  = 1'b0;
    end else begin
      sidx++;
      idle_now = model_idle;
      exp_rdy  = '0;
      if (idle_now && (|i_req_valid)) begin
        g       = rr_pick(model_last, i_req_valid);
        exp_rdy = NREQ'(1) << g;
        sb.push_back('{IDW'(g), to_bcd(int'(i_req_bin[8*g +: 8]))});
        model_last = g;
        model_idle = 1'b0;
        acc_idx    = sidx;
      end
      check(o_req_ready == exp_rdy, "req_ready", 32'(o_req_ready), 32'(exp_rdy));
      check(o_busy == !idle_now, "busy", 32'(o_busy), 32'(!idle_now));
      exp_valid = !idle_now && ((sidx - acc_idx) >= 9);
      check(o_out_valid == exp_valid, "out_valid", 32'(o_out_valid), 32'(exp_valid));
      if (o_out_valid) begin
        if (prev_hold) begin
          check({o_out_id, o_out_bcd} == {held_id, held_bcd}, "hold_stable",
                32'({o_out_id, o_out_bcd}), 32'({held_id, held_bcd}));
        end
        if (i_out_ready) begin
          check(sb.size() != 0, "unexpected_output", 32'(sb.size()), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check(o_out_bcd == e.bcd, "out_bcd", 32'(o_out_bcd), 32'(e.bcd));
            check(o_out_id == e.id, "out_id", 32'(o_out_id), 32'(e.id));
          end
          xfer_q.push_back(sidx);
          model_idle = 1'b1;
          prev_hold  = 1'b0;
        end else begin
          prev_hold = 1'b1;
          held_bcd  = o_out_bcd;
          held_id   = o_out_id;
        end
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  task automatic run_reqs(input logic [NREQ-1:0] mask, input logic [8*NREQ-1:0] vals);
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] gnt;
    int n;
    pend = mask;
    n    = 0;
    @(negedge clk);
    i_req_bin   = vals;
    i_req_valid = pend;
    while (pend != '0 && n < 500) begin
      #4;
      gnt = o_req_ready;
      @(negedge clk);
      pend        = pend & ~gnt;
      i_req_valid = pend;
      n++;
    end
    check(pend == '0, "grant_timeout", 32'(pend), 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(model_idle && sb.size() == 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(n < 300, "drain_timeout", 32'(n), 32'd300);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(o_out_valid == 1'b0, {tag, "_out_valid"}, 32'(o_out_valid), 32'd0);
    check(o_out_bcd == 12'h000, {tag, "_out_bcd"}, 32'(o_out_bcd), 32'd0);
    check(o_out_id == '0, {tag, "_out_id"}, 32'(o_out_id), 32'd0);
    check(o_busy == 1'b0, {tag, "_busy"}, 32'(o_busy), 32'd0);
    check(o_req_ready == '0, {tag, "_req_ready"}, 32'(o_req_ready), 32'd0);
  endtask

  initial begin
    int n;
    logic [NREQ-1:0] m;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #4;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesters at once: grants 0..3, results 10 cycles apart.
    xfer_q.delete();
    run_reqs(4'hF, {8'd40, 8'd30, 8'd20, 8'd10});
    wait_idle();
    check(xfer_q.size() == 4, "xfer_count", 32'(xfer_q.size()), 32'd4);
    for (int i = 1; i < xfer_q.size(); i++) begin
      check(xfer_q[i] - xfer_q[i-1] == 10, "throughput", 32'(xfer_q[i] - xfer_q[i-1]), 32'd10);
    end

    run_reqs(4'b0001, {24'h0, 8'd255});
    wait_idle();

    // Back-pressure: hold a 47 result for 20 cycles with another requester waiting.
    rdy_fix = 1'b0;
    run_reqs(4'b0001, {24'h0, 8'd47});
    n = 0;
    while (!o_out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(n < 50, "valid_timeout", 32'(n), 32'd50);
    i_req_bin   = {8'd0, 8'd99, 8'd0, 8'd47};
    i_req_valid = 4'b0100;
    repeat (20) @(negedge clk);
    check(o_out_bcd == 12'h047, "bp_bcd", 32'(o_out_bcd), 32'h047);
    rdy_fix = 1'b1;
    run_reqs(4'b0100, {8'd0, 8'd99, 8'd0, 8'd47});
    wait_idle();

    // Asynchronous reset part-way through converting 173.
    run_reqs(4'b1000, {8'd173, 24'h0});
    repeat (4) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_reqs(4'b0101, {8'd0, 8'd222, 8'd0, 8'd111});
    wait_idle();

    run_reqs(4'b1000, {8'd3, 24'h0});
    wait_idle();
    run_reqs(4'b0010, {16'h0, 8'd1, 8'h0});
    wait_idle();
    run_reqs(4'b1000, {8'd33, 24'h0});
    wait_idle();
    run_reqs(4'b0001, {24'h0, 8'd100});
    wait_idle();

    rdy_rand = 1'b1;
    for (int r = 0; r < 50; r++) begin
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      run_reqs(m, (8*NREQ)'($urandom));
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    rdy_rand = 1'b0;
    wait_idle();

    for (int v = 0; v < 256; v++) begin
      run_reqs(4'b0010, {16'h0, 8'(v), 8'h0});
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
